// File: rtl/hazard_pkg.sv
// Shared types and sizing for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned MAX_WAIT_DEF = 15;
  localparam int unsigned WAIT_W       = 8;
  localparam int unsigned PERF_W       = 16;
  localparam int unsigned REG_W        = 5;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic              IDEX_MemRead_i;
  logic [REG_W-1:0]  IDEX_Rt_i;
  logic [REG_W-1:0]  IFID_Rs_i;
  logic [REG_W-1:0]  IFID_Rt_i;
  logic              Jump_i;
  logic              BranchTaken_i;
  logic              MemReq_i;
  logic              MemReady_i;

  logic              PCWrite_o;
  logic              IFIDWrite_o;
  logic              IFIDFlush_o;
  logic              IDEXBubble_o;
  logic              PipeHold_o;
  logic              MEMWBBubble_o;
  logic              MemErr_o;
  logic [PERF_W-1:0] StallCnt_o;
  logic [PERF_W-1:0] FlushCnt_o;

  modport slave (
    input  IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i,
           Jump_i, BranchTaken_i, MemReq_i, MemReady_i,
    output PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o,
           PipeHold_o, MEMWBBubble_o, MemErr_o, StallCnt_o, FlushCnt_o
  );

  modport master (
    output IDEX_MemRead_i, IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i,
           Jump_i, BranchTaken_i, MemReq_i, MemReady_i,
    input  PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXBubble_o,
           PipeHold_o, MEMWBBubble_o, MemErr_o, StallCnt_o, FlushCnt_o
  );
endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating enable counter with asynchronous active-low clear.
module hazard_perf_cnt
  import hazard_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  output logic [PERF_W-1:0] cnt_o
);

  logic [PERF_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + PERF_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/bubble controller for a 5-stage pipeline with memory-wait timeout.
// Define HAZARD_PERF_EN to build the stall and flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  hazard_ctrl_if.slave  bus
);

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic              mem_stall, load_use, ctrl_flush;

  assign load_use   = bus.IDEX_MemRead_i && (bus.IDEX_Rt_i != '0) &&
                      ((bus.IDEX_Rt_i == bus.IFID_Rs_i) || (bus.IDEX_Rt_i == bus.IFID_Rt_i));
  assign ctrl_flush = bus.Jump_i || bus.BranchTaken_i;

  // Next state, wait counter and prioritised pipeline controls
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q || (wait_cnt_q == MAX_WAIT_C);
    mem_stall  = 1'b0;

    bus.PCWrite_o     = 1'b1;
    bus.IFIDWrite_o   = 1'b1;
    bus.IFIDFlush_o   = 1'b0;
    bus.IDEXBubble_o  = 1'b0;
    bus.PipeHold_o    = 1'b0;
    bus.MEMWBBubble_o = 1'b0;

    case (state_q)
      ST_RUN: begin
        mem_stall = bus.MemReq_i && !bus.MemReady_i;
        if (mem_stall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        mem_stall = !bus.MemReady_i;
        if (bus.MemReady_i) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Reset forces a safe drained pipeline regardless of hazards
    if (!rst_i) begin
      bus.PCWrite_o     = 1'b0;
      bus.IFIDWrite_o   = 1'b0;
      bus.IFIDFlush_o   = 1'b1;
      bus.IDEXBubble_o  = 1'b1;
      bus.MEMWBBubble_o = 1'b1;
    end else if (mem_stall) begin
      bus.PCWrite_o     = 1'b0;
      bus.IFIDWrite_o   = 1'b0;
      bus.PipeHold_o    = 1'b1;
      bus.MEMWBBubble_o = 1'b1;
    end else if (load_use) begin
      bus.PCWrite_o     = 1'b0;
      bus.IFIDWrite_o   = 1'b0;
      bus.IDEXBubble_o  = 1'b1;
    end else if (ctrl_flush) begin
      bus.IFIDFlush_o   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign bus.MemErr_o = mem_err_q;

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (!bus.PCWrite_o),
    .cnt_o (bus.StallCnt_o)
  );

  hazard_perf_cnt u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (bus.IFIDFlush_o),
    .cnt_o (bus.FlushCnt_o)
  );
`else
  assign bus.StallCnt_o = '0;
  assign bus.FlushCnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int unsigned MAXW = 15;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  hazard_ctrl_if bus ();

  hazard_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: memory-wait episode tracked as a flag plus elapsed waiting cycles
  bit m_in_wait;
  int m_wait_cycles;
  bit m_err;
  int m_stall;
  int m_flush;

  task automatic model_reset();
    m_in_wait = 0; m_wait_cycles = 0; m_err = 0; m_stall = 0; m_flush = 0;
  endtask

  // {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, PipeHold, MEMWBBubble}
  function automatic logic [5:0] exp_outs();
    bit mem, lu;
    if (!rst_i) return 6'b001101;
    mem = m_in_wait ? !bus.MemReady_i : (bus.MemReq_i && !bus.MemReady_i);
    lu  = bus.IDEX_MemRead_i && (bus.IDEX_Rt_i != 0) &&
          (bus.IDEX_Rt_i == bus.IFID_Rs_i || bus.IDEX_Rt_i == bus.IFID_Rt_i);
    if (mem) return 6'b000011;
    if (lu)  return 6'b000100;
    if (bus.Jump_i || bus.BranchTaken_i) return 6'b111000;
    return 6'b110000;
  endfunction

  function automatic logic [5:0] got_outs();
    return {bus.PCWrite_o, bus.IFIDWrite_o, bus.IFIDFlush_o,
            bus.IDEXBubble_o, bus.PipeHold_o, bus.MEMWBBubble_o};
  endfunction

  function automatic logic [15:0] exp_stall();
    return PERF ? 16'(m_stall) : 16'd0;
  endfunction

  function automatic logic [15:0] exp_flush();
    return PERF ? 16'(m_flush) : 16'd0;
  endfunction

  task automatic set_in(input bit mr, input logic [4:0] rt, input logic [4:0] rs,
                        input logic [4:0] frt, input bit j, input bit br,
                        input bit rq, input bit rdy);
    bus.IDEX_MemRead_i = mr;
    bus.IDEX_Rt_i      = rt;
    bus.IFID_Rs_i      = rs;
    bus.IFID_Rt_i      = frt;
    bus.Jump_i         = j;
    bus.BranchTaken_i  = br;
    bus.MemReq_i       = rq;
    bus.MemReady_i     = rdy;
  endtask

  // Advance one clock and update the model with the cycle's inputs
  task automatic tick();
    logic [5:0] e;
    e = exp_outs();
    @(posedge clk_i);
    if (rst_i) begin
      if (!e[5] && m_stall < 65535) m_stall++;
      if (e[3] && m_flush < 65535) m_flush++;
      if (m_in_wait) begin
        if (m_wait_cycles >= int'(MAXW) + 1) m_err = 1;
        if (bus.MemReady_i) m_in_wait = 0;
        else m_wait_cycles++;
      end else if (bus.MemReq_i && !bus.MemReady_i) begin
        m_in_wait = 1;
        m_wait_cycles = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    rst_i = 1'b0;
    set_in(1, 5'd3, 5'd3, 5'd0, 1, 0, 1, 0);
    @(posedge clk_i); #1;
    #4;
    n_total++;
    if (got_outs() !== 6'b001101) $display("FAIL reset_outs got=%b exp=%b", got_outs(), 6'b001101);
    else n_pass++;
    n_total++;
    if (bus.MemErr_o !== 1'b0) $display("FAIL reset_err got=%b exp=0", bus.MemErr_o);
    else n_pass++;
    n_total++;
    if (bus.StallCnt_o !== 16'd0 || bus.FlushCnt_o !== 16'd0)
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", bus.StallCnt_o, bus.FlushCnt_o);
    else n_pass++;
    tick();
    rst_i = 1'b1;
  endtask

  task automatic test_load_use();
    set_in(1, 5'd8, 5'd8, 5'd1, 0, 0, 0, 0);
    #4;
    n_total++;
    if (got_outs() !== 6'b000100) $display("FAIL load_use_rs got=%b exp=%b", got_outs(), 6'b000100);
    else n_pass++;
    tick();
    set_in(1, 5'd8, 5'd2, 5'd8, 0, 0, 0, 0);
    #4;
    n_total++;
    if (got_outs() !== exp_outs()) $display("FAIL load_use_rt got=%b exp=%b", got_outs(), exp_outs());
    else n_pass++;
    tick();
    set_in(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
    #4;
    n_total++;
    if (got_outs() !== 6'b110000) $display("FAIL load_use_r0 got=%b exp=%b", got_outs(), 6'b110000);
    else n_pass++;
    tick();
  endtask

  task automatic test_branch_vs_load_use();
    set_in(1, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0);
    #4;
    n_total++;
    if (bus.IDEXBubble_o !== 1'b1 || bus.IFIDFlush_o !== 1'b0)
      $display("FAIL branch_suppressed got=%b exp=%b", got_outs(), 6'b000100);
    else n_pass++;
    tick();
    set_in(0, 5'd8, 5'd8, 5'd0, 0, 1, 0, 0);
    #4;
    n_total++;
    if (got_outs() !== 6'b111000) $display("FAIL branch_flush got=%b exp=%b", got_outs(), 6'b111000);
    else n_pass++;
    tick();
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      #4;
      n_total++;
      if (got_outs() !== 6'b000011) $display("FAIL mem_wait_hold[%0d] got=%b exp=%b", i, got_outs(), 6'b000011);
      else n_pass++;
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    #4;
    n_total++;
    if (got_outs() !== 6'b110000) $display("FAIL mem_wait_release got=%b exp=%b", got_outs(), 6'b110000);
    else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    n_total++;
    if (got_outs() !== 6'b110000) $display("FAIL mem_wait_back_to_run got=%b exp=%b", got_outs(), 6'b110000);
    else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 20; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 1, 0);
      #4;
      n_total++;
      if (bus.MemErr_o !== m_err || got_outs() !== 6'b000011)
        $display("FAIL timeout_cyc[%0d] err got=%b exp=%b outs got=%b exp=%b",
                 i, bus.MemErr_o, m_err, got_outs(), 6'b000011);
      else n_pass++;
      tick();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    #4;
    n_total++;
    if (bus.MemErr_o !== 1'b1) $display("FAIL timeout_err_set got=%b exp=1", bus.MemErr_o);
    else n_pass++;
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    n_total++;
    if (bus.MemErr_o !== 1'b1 || got_outs() !== 6'b110000)
      $display("FAIL timeout_sticky err got=%b exp=1 outs got=%b exp=%b", bus.MemErr_o, got_outs(), 6'b110000);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    #2;
    rst_i = 1'b0;
    model_reset();
    #1;
    n_total++;
    if (got_outs() !== 6'b001101 || bus.MemErr_o !== 1'b0)
      $display("FAIL reset_mid_wait outs got=%b exp=%b err got=%b exp=0", got_outs(), 6'b001101, bus.MemErr_o);
    else n_pass++;
    tick();
    rst_i = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    n_total++;
    if (got_outs() !== 6'b110000) $display("FAIL reset_mid_wait_run got=%b exp=%b", got_outs(), 6'b110000);
    else n_pass++;
    tick();
  endtask

  task automatic test_perf();
    rst_i = 1'b0;
    model_reset();
    tick();
    rst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 5'd9, 5'd9, 5'd0, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 1, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    #4;
    n_total++;
    if (bus.StallCnt_o !== (PERF ? 16'd5 : 16'd0))
      $display("FAIL perf_stall got=%0d exp=%0d", bus.StallCnt_o, PERF ? 5 : 0);
    else n_pass++;
    n_total++;
    if (bus.FlushCnt_o !== (PERF ? 16'd2 : 16'd0))
      $display("FAIL perf_flush got=%0d exp=%0d", bus.FlushCnt_o, PERF ? 2 : 0);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
      #4;
      n_total++;
      if (got_outs() !== exp_outs() || bus.MemErr_o !== m_err ||
          bus.StallCnt_o !== exp_stall() || bus.FlushCnt_o !== exp_flush())
        $display("FAIL random[%0d] outs got=%b exp=%b err got=%b exp=%b stall got=%0d exp=%0d flush got=%0d exp=%0d",
                 i, got_outs(), exp_outs(), bus.MemErr_o, m_err,
                 bus.StallCnt_o, exp_stall(), bus.FlushCnt_o, exp_flush());
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_vs_load_use();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_perf();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
